// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand abs_val can handle; operands are zero-extended to this.
  localparam int unsigned ABS_MAX_WIDTH = 64;

  // Counter width for the default 32-bit configuration.
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_WIDTH  = $clog2(DEFAULT_DATA_WIDTH + 1);

  // Counter must hold the value DATA_WIDTH itself.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  // Conditional two's-complement magnitude. The caller keeps only its low
  // operand-width bits, and -v modulo 2^w is the magnitude we need, so the
  // most-negative value maps to 2^(w-1) with no special case.
  function automatic logic [ABS_MAX_WIDTH-1:0] abs_val(
    input logic [ABS_MAX_WIDTH-1:0] v,
    input logic                     negate
  );
    return negate ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between the multiplier and its user.
interface mult_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic                  signed_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] product_hi_o;
  logic [DATA_WIDTH-1:0] product_lo_o;

  modport master (
    output start_i, signed_i, a_i, b_i,
    input  busy_o, done_o, product_hi_o, product_lo_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i,
    output busy_o, done_o, product_hi_o, product_lo_o
  );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, signed
// operands handled by multiplying magnitudes and negating the result.
// DATA_WIDTH must be between 2 and ABS_MAX_WIDTH.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mult_seq_if.slave  bus
);

  localparam int                   CNT_WIDTH = cnt_width(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(1);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   mcand_reg, mcand_next;
  logic [DATA_WIDTH-1:0]   mplier_reg, mplier_next;   // low half of the shift chain
  logic [DATA_WIDTH-1:0]   acc_reg, acc_next;         // high half of the shift chain
  logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
  logic                    neg_reg, neg_next;
  logic [2*DATA_WIDTH-1:0] prod_reg, prod_next;

  logic [DATA_WIDTH:0]     sum;                       // accumulator plus carry
  logic [2*DATA_WIDTH-1:0] shifted;
  logic [2*DATA_WIDTH-1:0] final_prod;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;
  logic                    a_neg, b_neg;

  // Next-state, datapath step and operand capture.
  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    neg_next    = neg_reg;
    prod_next   = prod_reg;

    a_neg = bus.signed_i & bus.a_i[DATA_WIDTH-1];
    b_neg = bus.signed_i & bus.b_i[DATA_WIDTH-1];
    mag_a = DATA_WIDTH'(abs_val(ABS_MAX_WIDTH'(bus.a_i), a_neg));
    mag_b = DATA_WIDTH'(abs_val(ABS_MAX_WIDTH'(bus.b_i), b_neg));

    // Add the multiplicand when the multiplier LSB is set, then shift the
    // {carry, acc, multiplier} chain right by one.
    sum        = {1'b0, acc_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
    shifted    = {sum[DATA_WIDTH:1], sum[0], mplier_reg[DATA_WIDTH-1:1]};
    final_prod = neg_reg ? (~shifted + 1'b1) : shifted;

    unique case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          state_next  = RUN;
          mcand_next  = mag_a;
          mplier_next = mag_b;
          neg_next    = a_neg ^ b_neg;
          acc_next    = '0;
          cnt_next    = CNT_LOAD;
        end
      end
      RUN: begin
        acc_next    = shifted[2*DATA_WIDTH-1:DATA_WIDTH];
        mplier_next = shifted[DATA_WIDTH-1:0];
        cnt_next    = cnt_reg - 1'b1;
        // Products are loaded on the edge that enters DONE so they are
        // valid for the whole cycle in which done_o is high.
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
          prod_next  = final_prod;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      prod_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      neg_reg    <= neg_next;
      prod_reg   <= prod_next;
    end
  end

  // Status decoded from the registered state only.
  assign bus.busy_o       = (state_reg != IDLE);
  assign bus.done_o       = (state_reg == DONE);
  assign bus.product_hi_o = prod_reg[2*DATA_WIDTH-1:DATA_WIDTH];
  assign bus.product_lo_o = prod_reg[DATA_WIDTH-1:0];

endmodule
